// File: rtl/tx_round_robin_arbiter.sv
// Round-robin arbiter sharing one byte-wide transmit port among NUM_REQ producers.
// One byte per grant, with a watchdog on a transmitter that never starts.
module tx_round_robin_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = 2,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_byte,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           tx_byte,
  output logic                 transmit,
  input  logic                 is_transmitting,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [7:0]         byte_q, byte_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_q, tx_d;
  logic               err_q, err_d;
  logic               busy_q;

  logic [7:0]         byte_a [NUM_REQ];
  logic               pick_vld;
  logic [GRANT_W-1:0] pick_idx;
  logic [GRANT_W-1:0] scan_idx;
  logic [GRANT_W-1:0] nxt_ptr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign byte_a[g] = req_byte[8*g +: 8];
  end

  // Scan from the far end so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = GRANT_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign nxt_ptr = GRANT_W'((int'(grant_q) + 1) % NUM_REQ);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    to_cnt_d = to_cnt_q;
    grant_d  = grant_q;
    byte_d   = byte_q;
    ack_d    = '0;
    tx_d     = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld && !is_transmitting) begin
          grant_d  = pick_idx;
          byte_d   = byte_a[pick_idx];
          ack_d    = NUM_REQ'(1) << pick_idx;
          tx_d     = 1'b1;
          to_cnt_d = '0;
          state_d  = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (is_transmitting) begin
          state_d = S_WAIT_DONE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          rr_ptr_d = nxt_ptr;
          state_d  = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!is_transmitting) begin
          rr_ptr_d = nxt_ptr;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      to_cnt_q <= '0;
      grant_q  <= '0;
      byte_q   <= '0;
      ack_q    <= '0;
      tx_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      to_cnt_q <= to_cnt_d;
      grant_q  <= grant_d;
      byte_q   <= byte_d;
      ack_q    <= ack_d;
      tx_q     <= tx_d;
      err_q    <= err_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign ack         = ack_q;
  assign tx_byte     = byte_q;
  assign transmit    = tx_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_tx_round_robin_arbiter.sv
// Bench for tx_round_robin_arbiter: vector table, corner sequences,
// and random traffic against a cycle-level reference model.
module tb_tx_round_robin_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         n_reset;
  logic [N-1:0] req;
  logic [N*8-1:0] req_byte;
  logic [N-1:0] ack;
  logic [7:0]   tx_byte;
  logic         transmit;
  logic         is_transmitting;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;

  tx_round_robin_arbiter #(
    .NUM_REQ(N), .GRANT_W(2), .TIMEOUT(TO), .TO_W(7)
  ) dut (
    .clk(clk), .n_reset(n_reset), .req(req), .req_byte(req_byte),
    .ack(ack), .tx_byte(tx_byte), .transmit(transmit),
    .is_transmitting(is_transmitting), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_pulses = 0;

  // Reference model: phase 0 idle, 1 waiting for start, 2 waiting for end.
  int           m_phase, m_ptr, m_last, m_wait;
  logic [N-1:0] m_ack;
  logic         m_tx, m_err;
  logic [7:0]   m_byte;
  logic [1:0]   m_gid;

  task automatic model_step();
    m_ack = '0;
    m_tx  = 1'b0;
    if (!n_reset) begin
      m_phase = 0; m_ptr = 0; m_last = 0; m_wait = 0;
      m_err = 1'b0; m_byte = 8'h00; m_gid = 2'd0;
    end else if (m_phase == 0) begin
      if (req != 0 && !is_transmitting) begin
        int c;
        c = -1;
        for (int off = 0; off < N; off++)
          if (c < 0 && req[(m_ptr + off) % N]) c = (m_ptr + off) % N;
        m_last = c;
        m_byte = req_byte[8*c +: 8];
        m_gid  = 2'(c);
        m_ack  = N'(1) << c;
        m_tx   = 1'b1;
        m_wait = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (is_transmitting) m_phase = 2;
      else if (m_wait + 1 == TO) begin
        m_err = 1'b1; m_ptr = (m_last + 1) % N; m_phase = 0;
      end else m_wait++;
    end else begin
      if (!is_transmitting) begin
        m_ptr = (m_last + 1) % N; m_phase = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    ack_pulses += $countones(ack);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       ist;
    logic [3:0] ack;
    logic       tx;
    logic [7:0] byt;
    logic [1:0] gid;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs [22];

  function automatic logic [16:0] pack_out(logic [3:0] a, logic t,
      logic [7:0] b, logic [1:0] g, logic bz, logic e);
    return {a, t, b, g, bz, e};
  endfunction

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'h1, 1'b0, 4'h1, 1'b1, 8'hA5, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'h9, 1'b0, 4'h8, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'h1, 1'b1, 4'h0, 1'b0, 8'h44, 2'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 8'h44, 2'd3, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'h1, 1'b0, 4'h1, 1'b1, 8'hA5, 2'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'h2, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'h2, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 4'h2, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'h2, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 4'h2, 1'b0, 4'h2, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 8'h22, 2'd1, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 8'h22, 2'd1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 4'hF, 1'b0, 4'h4, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 4'hB, 1'b1, 4'h0, 1'b0, 8'h33, 2'd2, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 4'hB, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 4'hB, 1'b0, 4'h1, 1'b1, 8'hA5, 2'd0, 1'b1, 1'b0};

    n_reset = 1'b0;
    req = '0;
    req_byte = 32'h4433_22A5;
    is_transmitting = 1'b0;

    for (int i = 0; i < 22; i++) begin
      n_reset = vecs[i].rst_n;
      req = vecs[i].req;
      is_transmitting = vecs[i].ist;
      tick();
      chk($sformatf("vec%0d", i),
          32'(pack_out(ack, transmit, tx_byte, grant_id, busy, timeout_err)),
          32'(pack_out(vecs[i].ack, vecs[i].tx, vecs[i].byt,
                       vecs[i].gid, vecs[i].busy, vecs[i].err)));
    end

    // Fairness with every requester asserted.
    n_reset = 1'b0; req = '0; is_transmitting = 1'b0;
    tick();
    n_reset = 1'b1;
    req = 4'hF;
    ack_pulses = 0;
    for (int g = 0; g < 5; g++) begin
      int w;
      w = 0;
      while (transmit !== 1'b1 && w < 8) begin
        tick();
        w++;
      end
      chk($sformatf("fair_tx%0d", g), 32'(transmit), 32'd1);
      chk($sformatf("fair_gid%0d", g), 32'(grant_id), 32'(g % N));
      chk($sformatf("fair_ack%0d", g), 32'(ack), 32'(1 << (g % N)));
      is_transmitting = 1'b1;
      tick();
      is_transmitting = 1'b0;
      tick();
    end
    chk("fair_ack_count", 32'(ack_pulses), 32'd5);

    // Watchdog: transmitter never starts.
    n_reset = 1'b0; req = '0; is_transmitting = 1'b0;
    tick();
    n_reset = 1'b1;
    req = 4'b0100;
    tick();
    chk("to_grant", 32'({transmit, grant_id}), 32'({1'b1, 2'd2}));
    req = '0;
    begin
      int n;
      n = 0;
      while (timeout_err !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      chk("to_cycles", 32'(n), 32'(TO));
    end
    chk("to_idle", 32'(busy), 32'd0);
    req = 4'hF;
    tick();
    chk("to_next_gid", 32'(grant_id), 32'd3);
    chk("to_next_ack", 32'(ack), 32'h8);
    chk("to_sticky", 32'(timeout_err), 32'd1);

    // Random traffic against the reference model.
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      req = 4'($urandom_range(0, 15));
      req_byte = $urandom;
      if ($urandom_range(0, 19) == 0) is_transmitting = ~is_transmitting;
      n_reset = ($urandom_range(0, 499) != 0);
      tick();
      chk($sformatf("rand%0d", c),
          32'(pack_out(ack, transmit, tx_byte, grant_id, busy, timeout_err)),
          32'(pack_out(m_ack, m_tx, m_byte, m_gid, m_phase != 0, m_err)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
